// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// The optional macro MULDIV_EARLY_OUT_EN is consumed by muldiv_unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam int ITER_LAST = 31;

  function automatic logic is_mul(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negation, used for operand
// magnitudes and for the sign fixup of products, quotients and remainders.
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit writing LO/HI to both register-file ports.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
//
// state  | meaning
// S_IDLE | waiting for i_start, operands latched on acceptance
// S_RUN  | one radix-2 multiply or restoring-divide step per cycle
// S_FIX  | sign fixup / divide-by-zero override, outputs registered
// S_WB   | write-back cycle, enables pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = ITER_LAST + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic [4:0]      i_dest_lo,
  input  logic [4:0]      i_dest_hi,
  output logic            o_busy,
  output logic [XLEN-1:0] o_write_data,
  output logic [4:0]      o_write_reg,
  output logic            o_sig_reg_write,
  output logic [XLEN-1:0] o_write_data2,
  output logic [4:0]      o_write_reg2,
  output logic            o_sig_reg_write2,
  output logic            o_div_by_zero
);

  localparam logic [4:0] LP_LAST = 5'(ITER - 1);

  state_e            r_state;
  op_e               r_op;
  logic [4:0]        r_cnt;
  logic [4:0]        r_dest_lo;
  logic [4:0]        r_dest_hi;
  logic              r_neg_lo;
  logic              r_neg_hi;
  logic              r_dbz;
  logic [XLEN-1:0]   r_dividend;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;

  logic              w_start_signed;
  logic              w_start_mul;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_mul;
  logic [2*XLEN-1:0] w_acc_add;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_dvs;
  logic [XLEN:0]     w_sub;
  logic              w_ge;
  logic              w_done;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_start_signed = is_signed_op(op_e'(i_op));
  assign w_start_mul    = is_mul(op_e'(i_op));
  assign w_mul          = is_mul(r_op);

  muldiv_negate #(.W(XLEN)) u_abs_a (
    .i_neg (w_start_signed & i_operand_a[XLEN-1]),
    .i_val (i_operand_a),
    .o_val (w_abs_a)
  );

  muldiv_negate #(.W(XLEN)) u_abs_b (
    .i_neg (w_start_signed & i_operand_b[XLEN-1]),
    .i_val (i_operand_b),
    .o_val (w_abs_b)
  );

  // Multiply adds the left-shifting multiplicand, so no final realignment is needed on early exit.
  assign w_acc_add = r_acc + r_mcand;

  // Restoring divide: shifted remainder is 33 bits wide because remainder < divisor <= 2^32-1.
  assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
  assign w_dvs    = {1'b0, r_mcand[XLEN-1:0]};
  assign w_sub    = w_rem_sh - w_dvs;
  assign w_ge     = (w_rem_sh >= w_dvs);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_done = (r_cnt == LP_LAST) || (w_mul && (r_mplier[XLEN-1:1] == '0));
`else
  assign w_done = (r_cnt == LP_LAST);
`endif

  muldiv_negate #(.W(2*XLEN)) u_fix_prod (
    .i_neg (r_neg_lo),
    .i_val (r_acc),
    .o_val (w_prod)
  );

  muldiv_negate #(.W(XLEN)) u_fix_quo (
    .i_neg (r_neg_lo),
    .i_val (r_acc[XLEN-1:0]),
    .o_val (w_quo)
  );

  muldiv_negate #(.W(XLEN)) u_fix_rem (
    .i_neg (r_neg_hi),
    .i_val (r_acc[2*XLEN-1:XLEN]),
    .o_val (w_rem)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_op             <= OP_MULT;
      r_cnt            <= '0;
      r_dest_lo        <= '0;
      r_dest_hi        <= '0;
      r_neg_lo         <= 1'b0;
      r_neg_hi         <= 1'b0;
      r_dbz            <= 1'b0;
      r_dividend       <= '0;
      r_mplier         <= '0;
      r_acc            <= '0;
      r_mcand          <= '0;
      o_busy           <= 1'b0;
      o_write_data     <= '0;
      o_write_reg      <= '0;
      o_sig_reg_write  <= 1'b0;
      o_write_data2    <= '0;
      o_write_reg2     <= '0;
      o_sig_reg_write2 <= 1'b0;
      o_div_by_zero    <= 1'b0;
    end else begin
      o_sig_reg_write  <= 1'b0;
      o_sig_reg_write2 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op       <= op_e'(i_op);
            r_dest_lo  <= i_dest_lo;
            r_dest_hi  <= i_dest_hi;
            r_cnt      <= '0;
            r_dividend <= i_operand_a;
            r_mplier   <= w_abs_b;
            r_neg_lo   <= w_start_signed & (i_operand_a[XLEN-1] ^ i_operand_b[XLEN-1]);
            r_neg_hi   <= w_start_signed & ~w_start_mul & i_operand_a[XLEN-1];
            r_dbz      <= ~w_start_mul & (i_operand_b == '0);
            r_acc      <= w_start_mul ? '0 : {{XLEN{1'b0}}, w_abs_a};
            r_mcand    <= w_start_mul ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
            o_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_mul) begin
            if (r_mplier[0]) r_acc <= w_acc_add;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else if (w_ge) begin
            r_acc <= {w_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
          end else begin
            r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
          end
          if (w_done) r_state <= S_FIX;
        end
        S_FIX: begin
          if (w_mul) begin
            o_write_data  <= w_prod[XLEN-1:0];
            o_write_data2 <= w_prod[2*XLEN-1:XLEN];
          end else if (r_dbz) begin
            o_write_data  <= '1;
            o_write_data2 <= r_dividend;
          end else begin
            o_write_data  <= w_quo;
            o_write_data2 <= w_rem;
          end
          o_write_reg      <= r_dest_lo;
          o_write_reg2     <= r_dest_hi;
          o_sig_reg_write  <= (r_dest_lo != 5'd0);
          o_sig_reg_write2 <= (r_dest_hi != 5'd0);
          o_div_by_zero    <= r_dbz;
          r_state          <= S_WB;
        end
        S_WB: begin
          o_busy        <= 1'b0;
          o_div_by_zero <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [4:0]  dlo;
  logic [4:0]  dhi;
  logic        busy;
  logic [31:0] wdata;
  logic [4:0]  wreg;
  logic        wen;
  logic [31:0] wdata2;
  logic [4:0]  wreg2;
  logic        wen2;
  logic        dbz;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_op             (op),
    .i_operand_a      (opa),
    .i_operand_b      (opb),
    .i_dest_lo        (dlo),
    .i_dest_hi        (dhi),
    .o_busy           (busy),
    .o_write_data     (wdata),
    .o_write_reg      (wreg),
    .o_sig_reg_write  (wen),
    .o_write_data2    (wdata2),
    .o_write_reg2     (wreg2),
    .o_sig_reg_write2 (wen2),
    .o_div_by_zero    (dbz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi, output logic z);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    z  = 1'b0;
    case (m_op)
      2'd0: begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; end
      2'd1: begin up = ua * ub; lo = up[31:0]; hi = up[63:32]; end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a; z = 1'b1;
        end else if (m_op == 2'd2) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0];
        end
      end
    endcase
  endfunction

  // Cycles from the accepting edge to the write-back cycle.
  function automatic int exp_lat(input logic [1:0] m_op, input logic [31:0] b);
    int          lat;
    int          hb;
    logic [31:0] m;
    lat = 34;
    hb  = 0;
    m   = (m_op == 2'd0 && b[31]) ? (32'd0 - b) : b;
`ifdef MULDIV_EARLY_OUT_EN
    if (m_op[1] == 1'b0) begin
      for (int i = 0; i < 32; i++) if (m[i]) hb = i;
      lat = hb + 3;
    end
`else
    if (m == 32'd0) hb = 0;
`endif
    return lat;
  endfunction

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] l, input logic [4:0] h);
    logic [31:0] elo, ehi;
    logic        ez;
    logic        early;
    int          lat;
    model(o, a, b, elo, ehi, ez);
    lat = exp_lat(o, b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; dlo = l; dhi = h;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom; dlo = 5'($urandom); dhi = 5'($urandom);
    early = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if (wen || wen2 || !busy) early = 1'b1;
      @(negedge clk);
    end
    chk({name, " quiet/busy before wb"}, 64'(early), 64'd0);
    chk({name, " lo"}, 64'(wdata), 64'(elo));
    chk({name, " hi"}, 64'(wdata2), 64'(ehi));
    chk({name, " regs"}, 64'({wreg, wreg2}), 64'({l, h}));
    chk({name, " enables"}, 64'({wen, wen2}), 64'({l != 5'd0, h != 5'd0}));
    chk({name, " dbz/busy wb"}, 64'({dbz, busy}), 64'({ez, 1'b1}));
    @(negedge clk);
    chk({name, " after wb"}, 64'({busy, wen, wen2, dbz}), 64'd0);
    chk({name, " lo hold"}, 64'(wdata), 64'(elo));
  endtask

  initial begin
    logic        pulsed;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'd0; opa = '0; opb = '0; dlo = '0; dhi = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, wdata, wreg, wen, wen2, dbz}, 64'd0);
    chk("reset outputs2", 64'(wdata2), 64'd0);
    chk("reset reg2", 64'(wreg2), 64'd0);
    rst = 1'b0;

    do_op("mult -3*7", 2'd0, 32'hFFFF_FFFD, 32'd7, 5'd8, 5'd9);
    do_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 5'd2);
    do_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 5'd3, 5'd4);
    do_op("divu 100/0", 2'd3, 32'd100, 32'd0, 5'd5, 5'd6);
    do_op("dest_lo zero", 2'd1, 32'd3, 32'd4, 5'd0, 5'd5);
    do_op("div minint/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 5'd7);
    do_op("div -7/0", 2'd2, 32'hFFFF_FFF9, 32'd0, 5'd10, 5'd11);
    do_op("multu 5*3", 2'd1, 32'd5, 32'd3, 5'd12, 5'd13);
    do_op("mult 9*0", 2'd0, 32'd9, 32'd0, 5'd0, 5'd0);

    // Restart attempt mid-run, then reset mid-run: nothing may be written.
    @(negedge clk);
    start = 1'b1; op = 2'd1; opa = 32'd1234; opb = 32'd5678; dlo = 5'd3; dhi = 5'd4;
    @(negedge clk);
    start = 1'b0;
    pulsed = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (wen || wen2) pulsed = 1'b1;
      start = (k == 10);
      rst   = (k == 20);
      @(negedge clk);
    end
    start = 1'b0;
    chk("rst busy drop", 64'(busy), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wen || wen2 || busy) pulsed = 1'b1;
      @(negedge clk);
    end
    chk("rst no writes/no queued start", 64'(pulsed), 64'd0);
    do_op("after rst", 2'd3, 32'd1000, 32'd7, 5'd20, 5'd21);

    for (int t = 0; t < 24; t++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = 32'($urandom_range(1, 50));
        default: rb = 32'($urandom);
      endcase
      do_op($sformatf("rand%0d op%0d", t, ro), ro, ra, rb, 5'($urandom), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
